fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 49 ++++
 rtl/fetch_sequencer_wait_timer.sv | 31 +++
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU constants for the fetch sequencer: state encoding, defaults, strobe bundle.
package fetch_sequencer_pkg;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;
  localparam int unsigned OPCODE_W        = 4;
  localparam int unsigned COUNT_W         = 8;
  localparam logic [OPCODE_W-1:0] HLT_OPCODE_DEF = 4'hF;

  // ST_CLR is the single pc_clr cycle between run being sampled and the first ADDR.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_MEM   = 3'd3,
    ST_IRLD  = 3'd4,
    ST_EXEC  = 3'd5,
    ST_HALT  = 3'd6,
    ST_FAULT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic pc_incr;
    logic pc_clr;
    logic mar_load;
    logic ram_en;
    logic ir_load;
    logic exec_start;
    logic halted;
    logic fault;
  } ctrl_t;

  // Strobes that belong to a state for its whole duration (exec_start is handled by the caller).
  function automatic ctrl_t state_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_CLR:   c.pc_clr = 1'b1;
      ST_ADDR:  begin c.pc_en = 1'b1; c.mar_load = 1'b1; end
      ST_MEM:   c.ram_en = 1'b1;
      ST_IRLD:  begin c.ram_en = 1'b1; c.ir_load = 1'b1; c.pc_incr = 1'b1; end
      ST_HALT:  c.halted = 1'b1;
      ST_FAULT: c.fault = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_sequencer_wait_timer.sv
// Memory wait timer: counts enabled cycles, flags the LIMIT-th waiting cycle.
module fetch_sequencer_wait_timer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] count;

  // Count waiting cycles, holding at the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: ADDR/MEM/IRLD fetch loop with HALT and memory-timeout FAULT.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter logic [OPCODE_W-1:0] HLT_OPCODE  = HLT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic               mem_ready,
  input  logic               exec_done,
  output logic               pc_en,
  output logic               pc_incr,
  output logic               pc_clr,
  output logic               mar_load,
  output logic               ram_en,
  output logic               ir_load,
  output logic               exec_start,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] inst_count
);

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_next;
  logic   mem_tc;
  logic   timer_clear;
  logic   timer_enable;

  // Timer restarts on every MEM entry and only advances while memory is not ready.
  assign timer_clear  = (state != ST_MEM);
  assign timer_enable = (state == ST_MEM) && !mem_ready;

  fetch_sequencer_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tc     (mem_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mem_ready wins over the timeout in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (run) state_next = ST_CLR;
      ST_CLR:   state_next = ST_ADDR;
      ST_ADDR:  state_next = ST_MEM;
      ST_MEM: begin
        if (mem_ready)   state_next = ST_IRLD;
        else if (mem_tc) state_next = ST_FAULT;
      end
      ST_IRLD:  state_next = (opcode == HLT_OPCODE) ? ST_HALT : ST_EXEC;
      ST_EXEC:  if (exec_done) state_next = ST_ADDR;
      ST_HALT:  state_next = ST_HALT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode of the upcoming state so the registered strobes line up with it.
  always_comb begin
    ctrl_next            = state_ctrl(state_next);
    ctrl_next.exec_start = (state_next == ST_EXEC) && (state != ST_EXEC);
  end

  // Output register: strobes come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl <= '0;
    end else begin
      ctrl <= ctrl_next;
    end
  end

  // Fetched-instruction counter, bumped on IRLD entry and saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_count <= '0;
    end else if ((state_next == ST_IRLD) && (inst_count != '1)) begin
      inst_count <= inst_count + COUNT_W'(1);
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_incr    = ctrl.pc_incr;
  assign pc_clr     = ctrl.pc_clr;
  assign mar_load   = ctrl.mar_load;
  assign ram_en     = ctrl.ram_en;
  assign ir_load    = ctrl.ir_load;
  assign exec_start = ctrl.exec_start;
  assign halted     = ctrl.halted;
  assign fault      = ctrl.fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: a planned per-cycle schedule of inputs and expected strobes.
module tb_fetch_sequencer;

  localparam int unsigned TO  = 15;
  localparam logic [3:0]  HLT = 4'hF;

  // Expected strobe vector order: {pc_en, pc_incr, pc_clr, mar_load, ram_en, ir_load, exec_start, halted, fault}
  localparam logic [8:0] V_IDLE  = 9'h000;
  localparam logic [8:0] V_CLR   = 9'h040;
  localparam logic [8:0] V_ADDR  = 9'h120;
  localparam logic [8:0] V_MEM   = 9'h010;
  localparam logic [8:0] V_IRLD  = 9'h098;
  localparam logic [8:0] V_START = 9'h004;
  localparam logic [8:0] V_HALT  = 9'h002;
  localparam logic [8:0] V_FAULT = 9'h001;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] opcode;
  logic       mem_ready;
  logic       exec_done;
  logic       pc_en, pc_incr, pc_clr, mar_load, ram_en, ir_load, exec_start, halted, fault;
  logic [7:0] inst_count;
  logic [8:0] obs_vec;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       run;
    logic       mr;
    logic       done;
    logic [3:0] op;
    logic [8:0] vec;
    logic [7:0] cnt;
  } step_t;

  step_t       plan[$];
  int unsigned m_cnt;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .exec_done  (exec_done),
    .pc_en      (pc_en),
    .pc_incr    (pc_incr),
    .pc_clr     (pc_clr),
    .mar_load   (mar_load),
    .ram_en     (ram_en),
    .ir_load    (ir_load),
    .exec_start (exec_start),
    .halted     (halted),
    .fault      (fault),
    .inst_count (inst_count)
  );

  assign obs_vec = {pc_en, pc_incr, pc_clr, mar_load, ram_en, ir_load, exec_start, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  task automatic add(input logic r, input logic m, input logic [3:0] o, input logic d, input logic [8:0] v);
    step_t s;
    s.run  = r;
    s.mr   = m;
    s.op   = o;
    s.done = d;
    s.vec  = v;
    s.cnt  = 8'(m_cnt);
    plan.push_back(s);
  endtask

  // k idle cycles with run low, the cycle that samples run, then the pc_clr cycle.
  task automatic plan_start(input int k);
    repeat (k) add(1'b0, rb(), rop(), rb(), V_IDLE);
    add(1'b1, rb(), rop(), rb(), V_IDLE);
    add(rb(), rb(), rop(), rb(), V_CLR);
  endtask

  // One fetch: w not-ready MEM cycles, opcode op, e execute cycles before exec_done.
  // term: 0 continue, 1 halted, 2 faulted.
  task automatic plan_fetch(input int w, input logic [3:0] op, input int e, output int term);
    term = 0;
    add(rb(), rb(), rop(), rb(), V_ADDR);
    if (w >= int'(TO)) begin
      repeat (TO) add(rb(), 1'b0, rop(), rb(), V_MEM);
      term = 2;
      return;
    end
    repeat (w) add(rb(), 1'b0, rop(), rb(), V_MEM);
    add(rb(), 1'b1, rop(), rb(), V_MEM);
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    add(rb(), rb(), op, rb(), V_IRLD);
    if (op == HLT) begin
      term = 1;
      return;
    end
    for (int i = 0; i <= e; i++)
      add(rb(), rb(), rop(), (i == e), (i == 0) ? V_START : V_IDLE);
  endtask

  task automatic plan_stuck(input logic [8:0] v, input int n);
    repeat (n) add(rb(), rb(), rop(), rb(), v);
  endtask

  task automatic run_plan(input string name);
    foreach (plan[i]) begin
      @(negedge clk);
      run       = plan[i].run;
      mem_ready = plan[i].mr;
      opcode    = plan[i].op;
      exec_done = plan[i].done;
      check($sformatf("%s strobes step %0d", name, i), 16'(obs_vec), 16'(plan[i].vec));
      check($sformatf("%s inst_count step %0d", name, i), 16'(inst_count), 16'(plan[i].cnt));
      check($sformatf("%s bus_overlap step %0d", name, i), 16'(pc_en & ram_en), 16'h0);
    end
    plan.delete();
  endtask

  // Assert reset mid-cycle and check the asynchronous clear before any clock edge.
  task automatic do_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    run = 1'b0;
    #1;
    check({name, " reset strobes"}, 16'(obs_vec), 16'h0);
    check({name, " reset inst_count"}, 16'(inst_count), 16'h0);
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    int term;
    int nf;
    int w;
    n_checks  = 0;
    n_fail    = 0;
    m_cnt     = 0;
    rst       = 1'b0;
    run       = 1'b0;
    opcode    = 4'h0;
    mem_ready = 1'b0;
    exec_done = 1'b0;

    do_reset("power_on");

    // Basic fetch/execute timing with memory always ready.
    plan_start(0);
    plan_fetch(0, 4'h1, 1, term);
    plan_fetch(0, 4'h2, 0, term);
    run_plan("basic");
    do_reset("after_basic");

    // HLT on the first fetch, then sticky halt regardless of inputs.
    plan_start(2);
    plan_fetch(1, HLT, 0, term);
    plan_stuck(V_HALT, 20);
    run_plan("halt");
    do_reset("in_halt");

    // Memory never ready: fault after the full wait window.
    plan_start(1);
    plan_fetch(15, 4'h1, 0, term);
    plan_stuck(V_FAULT, 10);
    run_plan("timeout");
    do_reset("in_fault");

    // Ready arrives on the last allowed MEM cycle.
    plan_start(1);
    plan_fetch(14, 4'h3, 2, term);
    plan_fetch(0, HLT, 0, term);
    plan_stuck(V_HALT, 5);
    run_plan("last_chance");
    do_reset("after_last_chance");

    // Randomized sessions.
    for (int s = 0; s < 10; s++) begin
      plan_start(int'($urandom_range(0, 3)));
      nf   = int'($urandom_range(1, 8));
      term = 0;
      for (int f = 0; f < nf && term == 0; f++) begin
        w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 14));
        plan_fetch(w, rop(), int'($urandom_range(0, 4)), term);
      end
      if (term == 1) plan_stuck(V_HALT, 4);
      if (term == 2) plan_stuck(V_FAULT, 4);
      run_plan($sformatf("random%0d", s));
      do_reset($sformatf("after_random%0d", s));
    end

    // Long run of non-halting fetches: counter saturation.
    plan_start(0);
    for (int f = 0; f < 300; f++)
      plan_fetch(int'($urandom_range(0, 2)), 4'($urandom_range(0, 14)), int'($urandom_range(0, 2)), term);
    run_plan("saturate");
    check("saturated inst_count", 16'(inst_count), 16'h00FF);
    do_reset("after_saturate");

    // Reset while waiting in MEM, then restart only on run.
    plan_start(1);
    plan_fetch(0, 4'h5, 0, term);
    add(rb(), rb(), rop(), rb(), V_ADDR);
    repeat (4) add(rb(), 1'b0, rop(), rb(), V_MEM);
    run_plan("pre_mem_reset");
    do_reset("mid_mem");
    plan_start(3);
    plan_fetch(0, 4'h6, 1, term);
    run_plan("resume");
    do_reset("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
